// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: access size codes, FSM state encoding,
// the default datapath width and the misaligned-access predicate.
package riscv_pkg;

  localparam int DEF_WORD_BITWIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Size code 2'b11 is not a legal access and is treated like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return size[1] ? (a != 2'b00) : (size[0] & a[0]);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables and replicated write data, and
// load lane extraction with sign or zero extension.
module mem_align
  import riscv_pkg::*;
#(
  parameter int WORD_BITWIDTH = DEF_WORD_BITWIDTH,
  localparam int BE_W = WORD_BITWIDTH / 8
) (
  input  logic [1:0]               i_a,
  input  logic [2:0]               i_funct3,
  input  logic [WORD_BITWIDTH-1:0] i_store_data,
  input  logic [WORD_BITWIDTH-1:0] i_rdata,
  output logic [BE_W-1:0]          o_be,
  output logic [WORD_BITWIDTH-1:0] o_wdata,
  output logic [WORD_BITWIDTH-1:0] o_load_data
);

  logic [WORD_BITWIDTH-1:0] w_shift;

  // Enables shifted past lane 3 fall off the top of the BE_W-bit vector.
  always_comb begin
    w_shift     = i_rdata >> {i_a, 3'b000};
    o_be        = {BE_W{1'b1}} << i_a;
    o_wdata     = i_store_data;
    o_load_data = w_shift;
    case (i_funct3[1:0])
      SZ_BYTE: begin
        o_be        = BE_W'(1) << i_a;
        o_wdata     = {BE_W{i_store_data[7:0]}};
        o_load_data = i_funct3[2] ? {{(WORD_BITWIDTH-8){1'b0}}, w_shift[7:0]}
                                  : {{(WORD_BITWIDTH-8){w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        o_be        = BE_W'(3) << i_a;
        o_wdata     = {(BE_W/2){i_store_data[15:0]}};
        o_load_data = i_funct3[2] ? {{(WORD_BITWIDTH-16){1'b0}}, w_shift[15:0]}
                                  : {{(WORD_BITWIDTH-16){w_shift[15]}}, w_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM and MEM/WB registers plus a req/ack data-memory FSM.
// Define MEM_MISALIGN_CHECK_EN to suppress and flag misaligned half/word accesses.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int WORD_BITWIDTH    = DEF_WORD_BITWIDTH,
  parameter int REG_NUM_BITWIDTH = 5,
  localparam int BE_W = WORD_BITWIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ex_valid,
  input  logic [WORD_BITWIDTH-1:0]    ex_aluresult,
  input  logic [WORD_BITWIDTH-1:0]    ex_store_data,
  input  logic                        ex_memread,
  input  logic                        ex_memwrite,
  input  logic                        ex_regwrite,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
  input  logic [2:0]                  ex_funct3,
  output logic                        stall,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [WORD_BITWIDTH-1:0]    dmem_addr,
  output logic [BE_W-1:0]             dmem_be,
  output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
  input  logic                        dmem_ack,
  input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
  output logic [WORD_BITWIDTH-1:0]    fd_ex_mem_data,
  output logic [REG_NUM_BITWIDTH-1:0] ex_mem_rd,
  output logic                        ex_mem_regwrite,
  output logic [WORD_BITWIDTH-1:0]    fd_mem_wb_data,
  output logic [REG_NUM_BITWIDTH-1:0] wb_rd,
  output logic                        wb_regwrite,
  output logic                        misalign_err
);

  mem_state_e r_state, w_state_nxt;

  logic                        r_em_valid, r_em_memread, r_em_memwrite, r_em_regwrite, r_em_mis;
  logic [WORD_BITWIDTH-1:0]    r_em_alu, r_em_sdata;
  logic [REG_NUM_BITWIDTH-1:0] r_em_rd;
  logic [2:0]                  r_em_funct3;

  logic [WORD_BITWIDTH-1:0]    r_wb_data;
  logic [REG_NUM_BITWIDTH-1:0] r_wb_rd;
  logic                        r_wb_regwrite, r_wb_mis;

  logic                        w_ex_mis, w_ex_memop, w_stall, w_req;
  logic [BE_W-1:0]             w_be;
  logic [WORD_BITWIDTH-1:0]    w_wdata, w_load;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_ex_mis = is_misaligned(ex_funct3[1:0], ex_aluresult[1:0]);
`else
  assign w_ex_mis = 1'b0;
`endif

  assign w_ex_memop = ex_valid & (ex_memread | ex_memwrite) & ~w_ex_mis;
  assign w_req      = (r_state == ST_WAIT);
  assign w_stall    = w_req & ~dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A fresh request starts on every edge that accepts a mem op, including the ack edge.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_stall) w_state_nxt = w_ex_memop ? ST_WAIT : ST_IDLE;
  end

  // EX/MEM boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_em_valid    <= 1'b0;
      r_em_memread  <= 1'b0;
      r_em_memwrite <= 1'b0;
      r_em_regwrite <= 1'b0;
      r_em_mis      <= 1'b0;
      r_em_alu      <= '0;
      r_em_sdata    <= '0;
      r_em_rd       <= '0;
      r_em_funct3   <= '0;
    end else if (!w_stall) begin
      r_em_valid    <= ex_valid;
      r_em_memread  <= ex_memread;
      r_em_memwrite <= ex_memwrite;
      r_em_regwrite <= ex_regwrite;
      r_em_mis      <= w_ex_mis;
      r_em_alu      <= ex_aluresult;
      r_em_sdata    <= ex_store_data;
      r_em_rd       <= ex_rd;
      r_em_funct3   <= ex_funct3;
    end
  end

  mem_align #(.WORD_BITWIDTH(WORD_BITWIDTH)) u_align (
    .i_a         (r_em_alu[1:0]),
    .i_funct3    (r_em_funct3),
    .i_store_data(r_em_sdata),
    .i_rdata     (dmem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load)
  );

  // MEM/WB boundary: a stalled cycle retires a bubble so the pending op writes back once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_data     <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
      r_wb_mis      <= 1'b0;
    end else if (w_stall) begin
      r_wb_regwrite <= 1'b0;
      r_wb_mis      <= 1'b0;
    end else begin
      r_wb_data     <= r_em_memread ? w_load : r_em_alu;
      r_wb_rd       <= r_em_rd;
      r_wb_regwrite <= r_em_valid & r_em_regwrite & ~r_em_mis;
      r_wb_mis      <= r_em_valid & r_em_mis;
    end
  end

  assign stall           = w_stall;
  assign dmem_req        = w_req;
  assign dmem_we         = w_req & r_em_memwrite;
  assign dmem_addr       = w_req ? {r_em_alu[WORD_BITWIDTH-1:2], 2'b00} : '0;
  assign dmem_be         = w_req ? w_be : '0;
  assign dmem_wdata      = (w_req & r_em_memwrite) ? w_wdata : '0;
  assign fd_ex_mem_data  = r_em_alu;
  assign ex_mem_rd       = r_em_rd;
  assign ex_mem_regwrite = r_em_valid & r_em_regwrite & ~r_em_memread;
  assign fd_mem_wb_data  = r_wb_data;
  assign wb_rd           = r_wb_rd;
  assign wb_regwrite     = r_wb_regwrite;
  assign misalign_err    = r_wb_mis;

endmodule
